// File: rtl/comb_pkg.sv
// Shared definitions for the time-multiplexed comb filter: word format, FSM
// state encodings and the saturating adder used on the feedback write value.
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

package comb_pkg;

    localparam int unsigned FRAC      = `FIXED_POINT;
    localparam int unsigned WIDTH_DEF = 24;
    localparam int unsigned WORD      = WIDTH_DEF + FRAC;

    // Working width of sat_add; must cover 2*WORD of the widest instance.
    localparam int unsigned SAT_W = 128;

    localparam int unsigned ST_W = 3;

    // FSM state encodings
    localparam logic [ST_W-1:0] ST_CLEAR = 3'd0;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd1;
    localparam logic [ST_W-1:0] ST_RD    = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [ST_W-1:0] ST_DAMP  = 3'd4;
    localparam logic [ST_W-1:0] ST_FB    = 3'd5;
    localparam logic [ST_W-1:0] ST_WR    = 3'd6;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd7;

    // a + b clamped to the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] maxv;
        logic signed [SAT_W-1:0] minv;
        one  = SAT_W'(1);
        sum  = a + b;
        maxv = (one <<< (w - 1)) - one;
        minv = -maxv - one;
        if (sum > maxv) begin
            return maxv;
        end
        if (sum < minv) begin
            return minv;
        end
        return sum;
    endfunction

endpackage

// File: rtl/comb_filter_tdm_bram.sv
// Shared delay memory: simple dual-port RAM, synchronous 1-cycle read,
// contents are not reset (the CLEAR sweep zeroes them).
module tdm_delay_bram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned W     = 40,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/comb_filter_tdm.sv
// Multi-channel damped feedback comb (Freeverb style). All channels share one
// delay RAM and one multiply path; each channel takes RD/WAIT/DAMP/FB/WR.
module comb_filter_tdm
    import comb_pkg::*;
#(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MAXDELAY = 4096
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [CHANNELS-1:0][WIDTH+FRAC-1:0]        in,
    input  logic [CHANNELS-1:0][$clog2(MAXDELAY):0]    tau,
    input  logic [CHANNELS-1:0][WIDTH+FRAC-1:0]        gain,
    input  logic [CHANNELS-1:0][WIDTH+FRAC-1:0]        damp,
    input  logic                                       flush,
    output logic                                       out_valid,
    output logic [CHANNELS-1:0][WIDTH+FRAC-1:0]        out
);

    localparam int unsigned WW    = WIDTH + FRAC;
    localparam int unsigned AW    = $clog2(MAXDELAY);
    localparam int unsigned TW    = AW + 1;
    localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned ABW   = CW + AW;
    localparam int unsigned DEPTH = CHANNELS * MAXDELAY;

    logic [ST_W-1:0]                  state_q, state_d;
    logic [CW-1:0]                    ch_q, ch_d;
    logic [AW-1:0]                    ptr_q, ptr_d;
    logic [ABW-1:0]                   clr_q, clr_d;
    logic                             flush_pend_q, flush_pend_d;
    logic [CHANNELS-1:0][WW-1:0]      in_r_q, in_r_d;
    logic [CHANNELS-1:0][WW-1:0]      gain_r_q, gain_r_d;
    logic [CHANNELS-1:0][WW-1:0]      damp_r_q, damp_r_d;
    logic [CHANNELS-1:0][TW-1:0]      tau_r_q, tau_r_d;
    logic [CHANNELS-1:0][WW-1:0]      filt_q, filt_d;
    logic [CHANNELS-1:0][WW-1:0]      out_r_q, out_r_d;
    logic [CHANNELS-1:0][WW-1:0]      out_q, out_d;
    logic                             out_valid_q, out_valid_d;
    logic                             in_ready_q, in_ready_d;
    logic [WW-1:0]                    y_q, y_d;
    logic [WW-1:0]                    fb_q, fb_d;

    logic                             mem_we_c;
    logic [ABW-1:0]                   mem_waddr_c;
    logic [WW-1:0]                    mem_wdata_c;
    logic [ABW-1:0]                   mem_raddr_c;
    logic [WW-1:0]                    mem_rdata;

    logic signed [WW-1:0]             y_s, f_s, d_s, g_s, x_s;
    logic signed [WW:0]               diff_s;
    logic signed [2*WW:0]             dprod_s;
    logic signed [2*WW-1:0]           gprod_s;
    logic signed [WW-1:0]             filt_new_c;
    logic signed [WW-1:0]             fb_c;

    tdm_delay_bram #(
        .DEPTH (DEPTH),
        .W     (WW),
        .AW    (ABW)
    ) u_bram (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (mem_waddr_c),
        .wdata (mem_wdata_c),
        .raddr (mem_raddr_c),
        .rdata (mem_rdata)
    );

    // Read tap: channel base plus (ptr - tau) modulo the per-channel depth
    always_comb begin
        mem_raddr_c = {ch_q, AW'(ptr_q - AW'(tau_r_q[ch_q]))};
    end

    // Damping lowpass and saturated feedback for the active channel
    always_comb begin
        y_s        = $signed(y_q);
        f_s        = $signed(filt_q[ch_q]);
        d_s        = $signed(damp_r_q[ch_q]);
        g_s        = $signed(gain_r_q[ch_q]);
        x_s        = $signed(in_r_q[ch_q]);
        diff_s     = (WW+1)'(f_s) - (WW+1)'(y_s);
        dprod_s    = (2*WW+1)'(d_s) * (2*WW+1)'(diff_s);
        filt_new_c = y_s + WW'(dprod_s >>> FRAC);
        gprod_s    = (2*WW)'(g_s) * (2*WW)'(f_s);
        fb_c       = WW'(sat_add(SAT_W'(x_s), SAT_W'(gprod_s >>> FRAC), WW));
    end

    // Next-state, datapath updates and RAM write control
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        ptr_d        = ptr_q;
        clr_d        = clr_q;
        flush_pend_d = flush_pend_q | (flush & (state_q != ST_CLEAR));
        in_r_d       = in_r_q;
        gain_r_d     = gain_r_q;
        damp_r_d     = damp_r_q;
        tau_r_d      = tau_r_q;
        filt_d       = filt_q;
        out_r_d      = out_r_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        in_ready_d   = 1'b0;
        y_d          = y_q;
        fb_d         = fb_q;
        mem_we_c     = 1'b0;
        mem_waddr_c  = '0;
        mem_wdata_c  = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we_c     = 1'b1;
                mem_waddr_c  = clr_q;
                filt_d       = '0;
                flush_pend_d = 1'b0;
                if (clr_q == ABW'(DEPTH - 1)) begin
                    clr_d      = '0;
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    clr_d = clr_q + ABW'(1);
                end
            end
            ST_IDLE: begin
                if (flush_pend_q || flush) begin
                    flush_pend_d = 1'b0;
                    clr_d        = '0;
                    state_d      = ST_CLEAR;
                end else if (in_valid && in_ready_q) begin
                    in_r_d   = in;
                    gain_r_d = gain;
                    damp_r_d = damp;
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        if (tau[c] == '0) begin
                            tau_r_d[c] = TW'(1);
                        end else if (tau[c] > TW'(MAXDELAY)) begin
                            tau_r_d[c] = TW'(MAXDELAY);
                        end else begin
                            tau_r_d[c] = tau[c];
                        end
                    end
                    ch_d    = '0;
                    state_d = ST_RD;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                y_d     = mem_rdata;
                state_d = ST_DAMP;
            end
            ST_DAMP: begin
                filt_d[ch_q] = filt_new_c;
                state_d      = ST_FB;
            end
            ST_FB: begin
                fb_d    = fb_c;
                state_d = ST_WR;
            end
            ST_WR: begin
                mem_we_c      = 1'b1;
                mem_waddr_c   = {ch_q, ptr_q};
                mem_wdata_c   = fb_q;
                out_r_d[ch_q] = y_q;
                if (ch_q == CW'(CHANNELS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                out_d       = out_r_q;
                out_valid_d = 1'b1;
                ptr_d       = ptr_q + AW'(1);
                if (flush_pend_q || flush) begin
                    flush_pend_d = 1'b0;
                    clr_d        = '0;
                    state_d      = ST_CLEAR;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                clr_d   = '0;
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_CLEAR;
            ch_q         <= '0;
            ptr_q        <= '0;
            clr_q        <= '0;
            flush_pend_q <= 1'b0;
            in_r_q       <= '0;
            gain_r_q     <= '0;
            damp_r_q     <= '0;
            tau_r_q      <= '0;
            filt_q       <= '0;
            out_r_q      <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            y_q          <= '0;
            fb_q         <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            ptr_q        <= ptr_d;
            clr_q        <= clr_d;
            flush_pend_q <= flush_pend_d;
            in_r_q       <= in_r_d;
            gain_r_q     <= gain_r_d;
            damp_r_q     <= damp_r_d;
            tau_r_q      <= tau_r_d;
            filt_q       <= filt_d;
            out_r_q      <= out_r_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            y_q          <= y_d;
            fb_q         <= fb_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_comb_filter_tdm.sv
// Directed bench for comb_filter_tdm with 2 channels and 16-sample delays.
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

module tb_comb_filter_tdm;

    localparam int unsigned CH   = 2;
    localparam int unsigned MD   = 16;
    localparam int unsigned WID  = 24;
    localparam int unsigned FR   = `FIXED_POINT;
    localparam int unsigned WW   = WID + FR;
    localparam int unsigned TW   = $clog2(MD) + 1;

    localparam logic [WW-1:0] ONE  = WW'(1) << FR;
    localparam logic [WW-1:0] HALF = ONE >> 1;
    localparam logic [WW-1:0] QTR  = ONE >> 2;
    localparam logic [WW-1:0] MAXP = {1'b0, {(WW-1){1'b1}}};
    localparam logic [WW-1:0] MINN = {1'b1, {(WW-1){1'b0}}};

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     in_valid;
    logic                     in_ready;
    logic [CH-1:0][WW-1:0]    in_v;
    logic [CH-1:0][TW-1:0]    tau_v;
    logic [CH-1:0][WW-1:0]    gain_v;
    logic [CH-1:0][WW-1:0]    damp_v;
    logic                     flush;
    logic                     out_valid;
    logic [CH-1:0][WW-1:0]    out_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    comb_filter_tdm #(
        .WIDTH    (WID),
        .CHANNELS (CH),
        .MAXDELAY (MD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_v),
        .tau       (tau_v),
        .gain      (gain_v),
        .damp      (damp_v),
        .flush     (flush),
        .out_valid (out_valid),
        .out       (out_v)
    );

    task automatic wait_ready();
        int g;
        g = 0;
        while (in_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
    endtask

    // Offer one frame, return cycles from accepting edge to out_valid (-1 on timeout)
    task automatic send_frame(input logic [CH-1:0][WW-1:0] x, output int lat,
                              output logic [CH-1:0][WW-1:0] o);
        wait_ready();
        in_v     = x;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        o   = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                o   = out_v;
                break;
            end
        end
    endtask

    task automatic do_flush();
        wait_ready();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        wait_ready();
    endtask

    task automatic test_reset();
        int  ready_at;
        logic seen;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        n_checks++;
        if (out_v !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: out=%h valid=%b want 0/0", out_v, out_valid);
        end
        rstn     = 1'b1;
        ready_at = -1;
        seen     = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
            if (in_ready === 1'b1) begin
                ready_at = k;
                break;
            end
        end
        n_checks++;
        if (ready_at != 32) begin
            n_fail++;
            $display("FAIL clear_length: got %0d want 32", ready_at);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_no_out_valid: got %b want 0", seen);
        end
        n_checks++;
        if (out_v !== '0) begin
            n_fail++;
            $display("FAIL clear_out_zero: got %h want 0", out_v);
        end
    endtask

    task automatic test_impulse();
        logic [CH-1:0][WW-1:0] x;
        logic [CH-1:0][WW-1:0] o;
        logic [WW-1:0]         exp0;
        int                    lat;
        do_flush();
        tau_v  = '0;
        tau_v[0] = TW'(4);
        tau_v[1] = TW'(4);
        gain_v = '0;
        gain_v[0] = HALF;
        gain_v[1] = HALF;
        damp_v = '0;
        for (int f = 0; f < 13; f++) begin
            x = '0;
            if (f == 0) x[0] = ONE;
            send_frame(x, lat, o);
            case (f)
                4:       exp0 = ONE;
                8:       exp0 = HALF;
                12:      exp0 = QTR;
                default: exp0 = '0;
            endcase
            n_checks++;
            if (o[0] !== exp0) begin
                n_fail++;
                $display("FAIL impulse_out0 f%0d: got %h want %h", f, o[0], exp0);
            end
            n_checks++;
            if (o[1] !== '0) begin
                n_fail++;
                $display("FAIL impulse_out1 f%0d: got %h want 0", f, o[1]);
            end
            n_checks++;
            if (lat != 11) begin
                n_fail++;
                $display("FAIL impulse_latency f%0d: got %0d want 11", f, lat);
            end
        end
    endtask

    task automatic test_damping();
        logic [CH-1:0][WW-1:0] x;
        logic [CH-1:0][WW-1:0] o;
        logic [WW-1:0]         exp1;
        int                    lat;
        do_flush();
        tau_v    = '0;
        tau_v[0] = TW'(3);
        tau_v[1] = TW'(2);
        gain_v   = '0;
        gain_v[1] = HALF;
        damp_v   = '0;
        damp_v[1] = HALF;
        for (int f = 0; f < 5; f++) begin
            x = '0;
            if (f == 0) x[1] = ONE;
            send_frame(x, lat, o);
            case (f)
                2:       exp1 = ONE;
                4:       exp1 = QTR;
                default: exp1 = '0;
            endcase
            n_checks++;
            if (o[1] !== exp1) begin
                n_fail++;
                $display("FAIL damp_out1 f%0d: got %h want %h", f, o[1], exp1);
            end
            n_checks++;
            if (o[0] !== '0) begin
                n_fail++;
                $display("FAIL damp_out0 f%0d: got %h want 0", f, o[0]);
            end
        end
    endtask

    task automatic test_tau_bounds();
        logic [CH-1:0][WW-1:0] x;
        logic [CH-1:0][WW-1:0] o;
        logic [WW-1:0]         exp0;
        int                    lat;
        do_flush();
        tau_v  = '0;
        gain_v = '0;
        damp_v = '0;
        for (int f = 0; f < 3; f++) begin
            x = '0;
            if (f == 0) x[0] = ONE;
            send_frame(x, lat, o);
            exp0 = (f == 1) ? ONE : '0;
            n_checks++;
            if (o[0] !== exp0) begin
                n_fail++;
                $display("FAIL tau0_out0 f%0d: got %h want %h", f, o[0], exp0);
            end
        end
        do_flush();
        tau_v[0] = TW'(16);
        tau_v[1] = TW'(16);
        for (int f = 0; f < 18; f++) begin
            x = '0;
            if (f == 0) x[0] = ONE;
            send_frame(x, lat, o);
            exp0 = (f == 16) ? ONE : '0;
            n_checks++;
            if (o[0] !== exp0) begin
                n_fail++;
                $display("FAIL tau16_out0 f%0d: got %h want %h", f, o[0], exp0);
            end
        end
    endtask

    task automatic test_saturation();
        logic [CH-1:0][WW-1:0] x;
        logic [CH-1:0][WW-1:0] o;
        logic [WW-1:0]         exp0;
        logic [WW-1:0]         exp1;
        int                    lat;
        do_flush();
        tau_v     = '0;
        tau_v[0]  = TW'(1);
        tau_v[1]  = TW'(1);
        gain_v[0] = ONE << 1;
        gain_v[1] = ONE << 1;
        damp_v    = '0;
        for (int f = 0; f < 6; f++) begin
            x    = '0;
            x[0] = MAXP;
            x[1] = MINN;
            send_frame(x, lat, o);
            exp0 = (f == 0) ? '0 : MAXP;
            exp1 = (f == 0) ? '0 : MINN;
            n_checks++;
            if (o[0] !== exp0) begin
                n_fail++;
                $display("FAIL sat_pos f%0d: got %h want %h", f, o[0], exp0);
            end
            n_checks++;
            if (o[1] !== exp1) begin
                n_fail++;
                $display("FAIL sat_neg f%0d: got %h want %h", f, o[1], exp1);
            end
        end
    endtask

    task automatic test_flush_midframe();
        int lat;
        int ready_at;
        do_flush();
        tau_v  = '0;
        gain_v = '0;
        damp_v = '0;
        wait_ready();
        in_v     = '0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 5) flush = 1'b1;
            if (k == 6) flush = 1'b0;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        flush = 1'b0;
        n_checks++;
        if (lat != 11) begin
            n_fail++;
            $display("FAIL flush_frame_latency: got %0d want 11", lat);
        end
        ready_at = -1;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            if (j == 1) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL out_valid_pulse: got %b want 0", out_valid);
                end
            end
            if (in_ready === 1'b1) begin
                ready_at = j;
                break;
            end
        end
        n_checks++;
        if (ready_at != 32) begin
            n_fail++;
            $display("FAIL flush_clear_length: got %0d want 32", ready_at);
        end
    endtask

    task automatic test_reset_midframe();
        logic [CH-1:0][WW-1:0] x;
        logic [CH-1:0][WW-1:0] o;
        int                    lat;
        int                    ready_at;
        logic                  seen;
        do_flush();
        tau_v    = '0;
        tau_v[0] = TW'(1);
        tau_v[1] = TW'(1);
        gain_v   = '0;
        damp_v   = '0;
        x    = '0;
        x[0] = ONE;
        send_frame(x, lat, o);
        x = '0;
        send_frame(x, lat, o);
        n_checks++;
        if (o[0] !== ONE) begin
            n_fail++;
            $display("FAIL prereset_out0: got %h want %h", o[0], ONE);
        end
        wait_ready();
        in_v     = '0;
        in_v[0]  = ONE;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_v !== '0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: valid=%b out=%h ready=%b want 0/0/0",
                     out_valid, out_v, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        ready_at = -1;
        seen     = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
            if (in_ready === 1'b1) begin
                ready_at = k;
                break;
            end
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_no_valid: got %b want 0", seen);
        end
        n_checks++;
        if (ready_at != 32) begin
            n_fail++;
            $display("FAIL midframe_reset_clear: got %0d want 32", ready_at);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        in_v     = '0;
        tau_v    = '0;
        gain_v   = '0;
        damp_v   = '0;
        test_reset();
        test_impulse();
        test_damping();
        test_tau_bounds();
        test_saturation();
        test_flush_midframe();
        test_reset_midframe();
        test_impulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comb_filter_tdm.md
Name: comb_filter_tdm

Overview:
- Multi-channel feedback comb filter with lowpass damping in the feedback path (Freeverb-style). Successor to the single-channel comb.
- All channels share one delay BRAM and one multiplier, processed time-multiplexed in the fast clk domain.
- One frame, one sample per channel, is accepted per valid/ready handshake. The sample-rate strobe drives in_valid.
- Sits in the reverb chain ahead of the allpass stages.

Parameters:
- WIDTH, 24, integer bits; word WORD = WIDTH + `FIXED_POINT (signed fixed point).
- CHANNELS, 4, number of independent comb channels.
- MAXDELAY, 4096, per-channel delay capacity in samples; must be a power of two.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  frame available
- in_ready  out  1  block can accept a frame
- in  in  CHANNELS x WORD  per-channel input samples, signed
- tau  in  CHANNELS x $clog2(MAXDELAY)+1  per-channel delay in samples
- gain  in  CHANNELS x WORD  per-channel feedback gain, fixed point
- damp  in  CHANNELS x WORD  per-channel damping in [0, 1.0], fixed point
- flush  in  1  request zeroing of all delay memory and filter state
- out_valid  out  1  single-cycle pulse, out is valid
- out  out  CHANNELS x WORD  per-channel delayed output, held until the next out_valid

Behaviour:
- Reset (async assert, sync deassert in effect)
  - out, out_valid, in_ready, write pointer ptr, all filt[c] cleared to 0.
  - FSM enters CLEAR.
- CLEAR
  - Writes 0 to all CHANNELS*MAXDELAY words, one per cycle.
  - Zeroes filt[].
  - in_ready = 0; lasts exactly CHANNELS*MAXDELAY cycles, then IDLE.
- IDLE
  - in_ready = 1.
  - On in_valid && in_ready: latch in, gain, damp; latch tau clamped to [1, MAXDELAY] (0 -> 1); c = 0; go RD.
  - A pending flush takes priority over in_valid: go CLEAR.
- Per-channel sequence RD -> WAIT -> DAMP -> FB -> WR, 5 cycles per channel:
  - RD: BRAM read address = c*MAXDELAY + ((ptr - tau[c]) mod MAXDELAY).
  - WAIT: BRAM read latency, 1 cycle; y = read data.
  - DAMP: filt[c] <= y + ((damp[c] * (filt[c] - y)) >>> `FIXED_POINT).
  - FB: fb = in[c] + ((gain[c] * filt[c]) >>> `FIXED_POINT), saturated to the WORD signed range.
  - WR: write fb to c*MAXDELAY + ptr; out_r[c] <= y; if c == CHANNELS-1 go DONE, else c++ and go RD.
- DONE
  - out <= out_r; out_valid = 1 for one cycle.
  - ptr <= (ptr + 1) mod MAXDELAY (wrap-around).
  - Go IDLE, or CLEAR if a flush is pending.
- Latency: out_valid asserts exactly 5*CHANNELS + 1 cycles after the accepting edge. Next in_ready is the cycle after DONE.
- Arithmetic:
  - Products are 2*WORD signed, then arithmetic shift, then truncate. Only fb saturates.
  - damp = 0 gives a plain comb: out[n] = v[n-tau], v = x + g*v[n-tau].
- Boundaries:
  - tau = MAXDELAY reads the oldest word. This is legal because read precedes write within a channel.
  - flush asserted mid-frame is latched; the current frame completes with out_valid, then CLEAR runs.
  - flush in CLEAR is ignored.
  - rstn mid-frame: frame is discarded, no out_valid, CLEAR restarts.
  - in_valid while in_ready = 0 is not accepted. The source must hold in_valid until accepted.

Decomposition:
- Shared package comb_pkg holds:
  - state enum (CLEAR, IDLE, RD, WAIT, DAMP, FB, WR, DONE);
  - localparam WORD;
  - saturating-add function sat_add.
- Sub-module tdm_delay_bram: simple dual-port RAM, CHANNELS*MAXDELAY x WORD, synchronous 1-cycle read, no reset of contents.

Test Plan:
Common setup: CHANNELS = 2, MAXDELAY = 16, ONE = 1 << `FIXED_POINT.
1. Release rstn -> in_ready stays 0 for exactly 32 cycles, then 1; out = 0; out_valid never pulses during CLEAR.
2. Ch0: tau = 4, gain = ONE/2, damp = 0; impulse in = ONE at frame 0, then zeros -> out[0] = 0 at frames 0-3, ONE at frame 4, ONE/2 at frame 8, ONE/4 at frame 12; ch1 (in = 0) stays 0; out_valid exactly 11 cycles after each accept.
3. Damping: ch1 tau = 2, gain = ONE/2, damp = ONE/2, impulse ONE -> out[1] = ONE at frame 2 and ONE/4 at frame 4; filt[1] = ONE/2 after frame 2; ch0 unaffected.
4. tau = 0 -> behaves as tau = 1 (impulse ONE appears at frame 1); tau = 16 -> impulse appears at frame 16 across a ptr wrap.
5. Saturation: gain = 2*ONE, in = max positive every frame, tau = 1 -> written value clamps at max positive and never wraps negative.
6. Flush during RD of ch1 -> current frame completes with out_valid, then in_ready low for 32 cycles. Separately, rstn pulse mid-frame -> no out_valid, all outputs 0, CLEAR restarts; next impulse response matches test 2.
